// File: rtl/tdc_result_reader.sv
// TDC result reader: captures merged measurement words on done_in, buffers them in a FIFO and
// streams each as a HEADER-framed byte sequence. Define TDC_READER_SEQ_EN to add a sequence byte.
module tdc_result_reader #(
   parameter int unsigned DIG_OUT    = 24,
   parameter int unsigned DEPTH_LOG2 = 2,
   parameter logic [7:0]  HEADER     = 8'hA5
) (
   input  logic                  clk,
   input  logic                  irst_n,
   input  logic                  done_in,
   input  logic [DIG_OUT-1:0]    word_in,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic                  clear_ovf,
   output logic                  overflow,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic                  busy
);

   localparam int unsigned Depth  = 1 << DEPTH_LOG2;
   localparam int unsigned NBytes = (DIG_OUT + 7) / 8;
   localparam int unsigned ShW    = NBytes * 8;
   localparam int unsigned IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;
   localparam int unsigned PtrW   = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {
      StIdle,
      StHdr,
      StData
`ifdef TDC_READER_SEQ_EN
      , StSeq
`endif
   } state_e;

   state_e                 state_q, state_d;
   logic [IdxW-1:0]        idx_q, idx_d;
   logic [ShW-1:0]         sh_q, sh_d;
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                   overflow_q, overflow_d;
   logic [DIG_OUT-1:0]     mem_q [Depth];
   logic [DEPTH_LOG2-1:0]  wr_idx, rd_idx;
   logic [PtrW-1:0]        level;
   logic                   full, pop, push, drop;
   logic [7:0]             byte_sel;

`ifdef TDC_READER_SEQ_EN
   logic [7:0] seq_cnt_q;
   logic [7:0] seq_mem_q [Depth];
   logic [7:0] seq_frame_q, seq_frame_d;
`endif

   // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
   always_comb begin
      level      = wr_ptr_q - rd_ptr_q;
      full       = (level == PtrW'(Depth));
      pop        = (state_q == StIdle) && (level != '0);
      push       = done_in && (!full || pop);
      drop       = done_in && full && !pop;
      wr_idx     = wr_ptr_q[DEPTH_LOG2-1:0];
      rd_idx     = rd_ptr_q[DEPTH_LOG2-1:0];
      wr_ptr_d   = wr_ptr_q + PtrW'(push);
      rd_ptr_d   = rd_ptr_q + PtrW'(pop);
      overflow_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : overflow_q);
   end

   always_ff @(posedge clk or negedge irst_n) begin
      if (!irst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_idx] <= word_in;
`ifdef TDC_READER_SEQ_EN
         seq_mem_q[wr_idx] <= seq_cnt_q;
`endif
      end
   end

`ifdef TDC_READER_SEQ_EN
   always_ff @(posedge clk or negedge irst_n) begin
      if (!irst_n) begin
         seq_cnt_q <= 8'h00;
      end else if (push) begin
         seq_cnt_q <= seq_cnt_q + 8'h01;
      end
   end
`endif

   // FSM state and datapath registers
   always_ff @(posedge clk or negedge irst_n) begin
      if (!irst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         sh_q    <= '0;
`ifdef TDC_READER_SEQ_EN
         seq_frame_q <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
`ifdef TDC_READER_SEQ_EN
         seq_frame_q <= seq_frame_d;
`endif
      end
   end

   // FSM next state; tx_valid is high in every non-idle state, so tx_ready alone means accept.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
`ifdef TDC_READER_SEQ_EN
      seq_frame_d = seq_frame_q;
`endif
      case (state_q)
         StIdle: begin
            if (pop) begin
               sh_d    = ShW'(mem_q[rd_idx]);
               idx_d   = '0;
               state_d = StHdr;
`ifdef TDC_READER_SEQ_EN
               seq_frame_d = seq_mem_q[rd_idx];
`endif
            end
         end
         StHdr: begin
            if (tx_ready) begin
`ifdef TDC_READER_SEQ_EN
               state_d = StSeq;
`else
               state_d = StData;
`endif
            end
         end
`ifdef TDC_READER_SEQ_EN
         StSeq: begin
            if (tx_ready) state_d = StData;
         end
`endif
         StData: begin
            if (tx_ready) begin
               if (idx_q == IdxW'(NBytes - 1)) begin
                  state_d = StIdle;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // MSB-first byte selection
   always_comb begin
      byte_sel = 8'h00;
      for (int i = 0; i < int'(NBytes); i++) begin
         if (idx_q == IdxW'(int'(NBytes) - 1 - i)) byte_sel = sh_q[i*8 +: 8];
      end
   end

   // FSM outputs
   always_comb begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      case (state_q)
         StHdr: begin
            tx_valid = 1'b1;
            tx_data  = HEADER;
         end
`ifdef TDC_READER_SEQ_EN
         StSeq: begin
            tx_valid = 1'b1;
            tx_data  = seq_frame_q;
         end
`endif
         StData: begin
            tx_valid = 1'b1;
            tx_data  = byte_sel;
         end
         default: ;
      endcase
   end

   assign overflow   = overflow_q;
   assign fifo_level = level;
   assign busy       = (state_q != StIdle) || (level != '0);

endmodule
